// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential Booth multiplier.
//   state_t    : FSM state encoding (IDLE, RUN)
//   BOOTH_ADD  : {q0, q-1} pair that adds the multiplicand
//   BOOTH_SUB  : {q0, q-1} pair that subtracts the multiplicand
//   calc_cnt_w : iteration counter width for a given operand width
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // The counter must be able to hold WIDTH+1, the final step index.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   Parameter XW : width of each accumulator half (operand width + 1)
//   upper    in  : upper half of the accumulator
//   lower    in  : lower half of the accumulator (holds the remaining multiplier bits)
//   a_ext    in  : extended multiplicand
//   pair     in  : {q0, q-1} Booth pair
//   acc_next out : accumulator after add/sub and arithmetic shift right by one
module booth_step
  import mult_pkg::*;
#(
  parameter int XW = 33
) (
  input  logic [XW-1:0]   upper,
  input  logic [XW-1:0]   lower,
  input  logic [XW-1:0]   a_ext,
  input  logic [1:0]      pair,
  output logic [2*XW-1:0] acc_next
);

  logic [XW-1:0] sum;

  // Upper-half add/subtract; wraps modulo 2^XW, which the extra
  // operand bit makes safe for every input value.
  always_comb begin
    sum = upper;
    case (pair)
      BOOTH_ADD: sum = upper + a_ext;
      BOOTH_SUB: sum = upper - a_ext;
      default:   sum = upper;
    endcase
  end

  // Arithmetic shift right of {sum, lower}; lower[0] is consumed by the caller as the new q-1.
  assign acc_next = {sum[XW-1], sum, lower[XW-1:1]};

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier for MULT/MULTU,
// owning the architectural HI/LO registers.
//   Parameter WIDTH : operand width (4..64); hi/lo are WIDTH bits each
//   clk, reset      : clock, asynchronous active-high reset
//   start           : request, sampled only in IDLE
//   is_signed       : 1 = two's complement operands, 0 = unsigned
//   accumulate      : (only with MULT_ACC_EN defined) add product into {hi,lo}
//   a, b            : multiplicand / multiplier, sampled with start
//   busy            : operation in flight
//   done            : one-cycle pulse, hi/lo valid from that cycle
//   hi, lo          : upper / lower halves of the 2*WIDTH-bit result
// Optional feature macro: MULT_ACC_EN (MADD/MADDU accumulate mode).
module booth_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
`ifdef MULT_ACC_EN
  input  logic             accumulate,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam int XW    = WIDTH + 1;
  localparam int AW    = 2 * XW;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [XW-1:0]    a_ext_r;
  logic [AW-1:0]    acc;
  logic             q_m1;
  logic [AW-1:0]    acc_next;
  logic [2*WIDTH-1:0] product;
`ifdef MULT_ACC_EN
  logic             acc_mode;
`endif

  booth_step #(
    .XW(XW)
  ) u_step (
    .upper   (acc[AW-1:XW]),
    .lower   (acc[XW-1:0]),
    .a_ext   (a_ext_r),
    .pair    ({acc[0], q_m1}),
    .acc_next(acc_next)
  );

  // The product is taken from the step being completed this edge.
  assign product = acc_next[2*WIDTH-1:0];

  // Control FSM: latches operands on start, runs WIDTH+1 Booth steps,
  // then commits the result to hi/lo and pulses done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      a_ext_r <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
`ifdef MULT_ACC_EN
      acc_mode <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_ext_r <= {is_signed & a[WIDTH-1], a};
            acc     <= {{XW{1'b0}}, is_signed & b[WIDTH-1], b};
            q_m1    <= 1'b0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef MULT_ACC_EN
            acc_mode <= accumulate;
`endif
          end
        end
        RUN: begin
          acc   <= acc_next;
          q_m1  <= acc[0];
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH)) begin
`ifdef MULT_ACC_EN
            if (acc_mode) begin
              {hi, lo} <= {hi, lo} + product;
            end else begin
              {hi, lo} <= product;
            end
`else
            {hi, lo} <= product;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: self-checking bench for booth_seq_mult (WIDTH=32).
// Expected results come from plain 64-bit integer multiplication.
// With MULT_ACC_EN defined, the accumulate port is driven and exercised.
module tb_booth_seq_mult;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             is_signed;
`ifdef MULT_ACC_EN
  logic             accumulate;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] model_hilo = '0;

  booth_seq_mult #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
`ifdef MULT_ACC_EN
    .accumulate(accumulate),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Reference: exact product of the operands interpreted per mode, modulo 2^64.
  function automatic logic [63:0] model_product(input logic sgn, input logic [31:0] x,
                                                input logic [31:0] y);
    longint xv;
    longint yv;
    xv = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    yv = sgn ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(xv * yv);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Caller is at a negedge; start is held across exactly one posedge.
  task automatic launch(input logic sgn, input logic accm, input logic [31:0] x,
                        input logic [31:0] y);
    start     = 1'b1;
    is_signed = sgn;
    a         = x;
    b         = y;
`ifdef MULT_ACC_EN
    accumulate = accm;
`else
    if (accm) $display("[TB] accumulate request ignored in base build");
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done, checking hi/lo hold their old value meanwhile.
  task automatic waitDone(input int already, output int lat);
    logic stable;
    stable = 1'b1;
    lat    = already;
    while (done !== 1'b1 && lat < 200) begin
      if ({hi, lo} !== model_hilo) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput("hilo_stable_run", {63'b0, stable}, 64'd1);
  endtask

  // Completes one operation and compares latency, busy and result.
  task automatic finishOp(input string tag, input logic sgn, input logic accm,
                          input logic [31:0] x, input logic [31:0] y, input int already);
    int lat;
    logic [63:0] p;
    waitDone(already, lat);
    p = model_product(sgn, x, y);
`ifdef MULT_ACC_EN
    model_hilo = accm ? model_hilo + p : p;
`else
    model_hilo = p;
`endif
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LAT));
    checkOutput({tag, "_busy"}, {63'b0, busy}, 64'd0);
    checkOutput({tag, "_hilo"}, {hi, lo}, model_hilo);
  endtask

  task automatic applyStimulus(input string tag, input logic sgn, input logic accm,
                               input logic [31:0] x, input logic [31:0] y);
    launch(sgn, accm, x, y);
    checkOutput({tag, "_busy_run"}, {63'b0, busy}, 64'd1);
    finishOp(tag, sgn, accm, x, y, 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
`ifdef MULT_ACC_EN
    accumulate = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_state", {60'b0, busy, done, |hi, |lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed values, including the most-negative operand.
    applyStimulus("s_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checkOutput("s_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus("u_ff_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("u_ff_ff_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus("s_ff_ff", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("s_ff_ff_const", {hi, lo}, 64'h0000_0000_0000_0001);
    applyStimulus("s_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    checkOutput("s_min_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
    applyStimulus("s_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1);
    checkOutput("s_min_1_const", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
    applyStimulus("u_min_min", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);

    // Start during RUN is ignored; operands are not re-sampled.
    launch(1'b0, 1'b0, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    a         = 32'hDEAD_BEEF;
    b         = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    finishOp("ignore_start", 1'b0, 1'b0, 32'd12345, 32'd678, 10);

    // Start in the done cycle is accepted.
    launch(1'b1, 1'b0, 32'hFFFF_FF00, 32'd300);
    checkOutput("b2b_done_low", {62'b0, done, busy}, 64'd1);
    finishOp("b2b", 1'b1, 1'b0, 32'hFFFF_FF00, 32'd300, 0);
    @(negedge clk);

    // Random operands and modes.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      applyStimulus("random", rs, 1'b0, ra, rb);
    end

    // Reset mid-operation discards it.
    launch(1'b1, 1'b0, 32'h0101_0101, 32'h7777_7777);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset", {60'b0, busy, done, |hi, |lo}, 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    model_hilo = '0;
    dones      = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("no_done_after_reset", 64'(dones), 64'd0);
    applyStimulus("after_reset", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd6);

`ifdef MULT_ACC_EN
    applyStimulus("acc_base", 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
    applyStimulus("acc_add", 1'b0, 1'b1, 32'd1, 32'd1);
    checkOutput("acc_add_const", {hi, lo}, 64'h0000_0001_0000_0000);
    applyStimulus("acc_signed", 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    applyStimulus("acc_off", 1'b1, 1'b0, 32'd5, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Parametrised sequential radix-2 Booth multiplier with a start/done handshake and a signed/unsigned mode, serving MULT and MULTU in the MIPS datapath.
- Owns the architectural HI/LO result registers and holds them until the next completion.
- Driven by the control unit, which stalls on busy.
- Handles every operand value, including the most-negative one, exactly, with no special-casing.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; legal range 4..64.
CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; hi/lo valid from that cycle
hi  output  WIDTH  upper WIDTH bits of the 2*WIDTH product
lo  output  WIDTH  lower WIDTH bits of the 2*WIDTH product

Behaviour:
- Reset (async, any state, including mid-operation): FSM goes to IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal product/Booth bit cleared. The in-flight operation is discarded; no done is produced.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start=1 at edge E0.
  - RUN -> IDLE at the edge where the counter reaches WIDTH+1.
- At E0:
  - Operands are extended to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - Accumulator is set to {zeros(WIDTH+1), b_ext}; previous Booth bit is set to 0; counter is set to 0.
- Each edge in RUN performs one Booth step on the (2*WIDTH+2)-bit accumulator:
  - Pair {q0, q-1} = 10: subtract a_ext from the upper half.
  - Pair 01: add a_ext to the upper half.
  - Pairs 00/11: no change.
  - Then arithmetic shift right by 1; q-1 takes the old q0; counter increments.
  - Upper-half arithmetic is WIDTH+1 bits wide, wraps modulo 2^(WIDTH+1), and carries no overflow flag.
- Completion:
  - Completion happens at edge E(WIDTH+1), i.e. after WIDTH+1 steps.
  - At that edge, {hi,lo} is written with the low 2*WIDTH bits of the accumulator.
  - done=1 for exactly one cycle after that edge.
- Latency: done is high in the cycle following edge E(WIDTH+1); that is 33 edges after the start edge for WIDTH=32.
- busy: 1 from after E0 through E(WIDTH+1); 0 in the done cycle.
- start while busy=1 is ignored; operands are not re-sampled.
- start during the done cycle is accepted (FSM is already IDLE); back-to-back throughput is one result per WIDTH+2 cycles.
- hi/lo change only at a completion edge or on reset; they are stable during RUN.
- Most-negative signed operand (a or b = 2^(WIDTH-1)): the extended width produces the exact product; no correction step.

Optional Feature:
Macro MULT_ACC_EN.
- Defined:
  - Adds input port `accumulate` (1 bit), sampled with start.
  - When accumulate=1, the completion edge writes {hi,lo} <= {hi,lo} + product (2*WIDTH-bit add, modulo 2^(2*WIDTH)), implementing MADD/MADDU.
  - Latency is unchanged.
  - When accumulate=0, behaviour is identical to the base block.
- Not defined: no port; {hi,lo} is always overwritten.

Decomposition:
- Package mult_pkg holds:
  - state enum (IDLE, RUN);
  - the CNT_W computation function;
  - localparam for the Booth pair encodings (BOOTH_ADD=01, BOOTH_SUB=10).
- Sub-module booth_step: combinational; inputs are upper half, a_ext and the {q0,q-1} pair; output is the next accumulator after add/sub and arithmetic shift. It is instantiated once.
- Sequential control (FSM, counter, hi/lo, done) stays in booth_seq_mult.

Test Plan:
- Signed, a=7, b=-3 -> after 33 edges, done pulses; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low in the done cycle.
- Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Signed with the same operands -> hi=0x00000000, lo=0x00000001.
- Signed, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start pulsed at cycle 10 of RUN with different operands -> ignored; result matches the first operands. Start in the done cycle -> second result arrives 33 edges later.
- Reset asserted mid-RUN at cycle 15 -> busy, done, hi, lo = 0 immediately; no done pulse follows; the next start completes normally.
- With MULT_ACC_EN defined: {hi,lo}=0x00000000_FFFFFFFF, then unsigned accumulate with a=1, b=1 -> hi=0x00000001, lo=0x00000000.
